// File: rtl/h_ram8_clr_pkg.sv
// Shared sizes and FSM encoding for the h_ram8_clr register memory.
package h_ram8_clr_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned RAM8_DEPTH = 8;
   localparam int unsigned ADDR8_W    = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } ram8_state_t;

endpackage

// File: rtl/h_word_reg.sv
// WIDTH-bit storage word with load enable and async active-high reset to zero.
module h_word_reg #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/h_ram8_clr.sv
// Eight-word register memory with a sequenced 8-cycle clear engine.
// Define H_RAM8_CLR_BYPASS_EN for write-through reads of the word being loaded.
module h_ram8_clr
   import h_ram8_clr_pkg::*;
#(
   parameter int unsigned      WIDTH   = WORD_W,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic               load,
   input  logic [ADDR8_W-1:0] address,
   input  logic               clear,
   output logic [WIDTH-1:0]   out,
   output logic               busy
);

   ram8_state_t             state, state_next;
   logic [ADDR8_W-1:0]      cnt, cnt_next;
   logic [RAM8_DEPTH-1:0]   we;
   logic [WIDTH-1:0]        wdata;
   logic [WIDTH-1:0]        word_q [RAM8_DEPTH];

   // State, sweep counter and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         busy  <= (state_next == SWEEP);
      end
   end

   // Next state plus write enable/data: clear beats load, sweep owns the array
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      we         = '0;
      wdata      = in;
      case (state)
         IDLE: begin
            if (clear) begin
               state_next = SWEEP;
               cnt_next   = '0;
            end else if (load) begin
               we = RAM8_DEPTH'(1) << address;
            end
         end
         SWEEP: begin
            we       = RAM8_DEPTH'(1) << cnt;
            wdata    = CLR_VAL;
            cnt_next = cnt + ADDR8_W'(1);
            if (cnt == ADDR8_W'(RAM8_DEPTH - 1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
      h_word_reg #(.WIDTH(WIDTH)) u_word (
         .clk  (clk),
         .rst  (rst),
         .load (we[i]),
         .d    (wdata),
         .q    (word_q[i])
      );
   end

   // Read select
   always_comb begin
      out = word_q[address];
`ifdef H_RAM8_CLR_BYPASS_EN
      if (load && (state == IDLE) && !clear) out = in;
`endif
   end

endmodule
